// File: rtl/de_pkg.sv
// -----------------------------------------------------------------------------
// de_pkg -- shared constants for the decode stage (de_pipe) and its register
// file (de_regfile).
//   NOP_INSTR  : canonical RV32 NOP (addi x0, x0, 0), loaded on reset/flush
//   REG_IDX_W  : width of an architectural register index field
//   *_LSB      : bit positions of rs1/rs2/rd fields in an RV32 instruction word
//   idx_in_range(): true when a register index is below the configured count
// -----------------------------------------------------------------------------
package de_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned RD_LSB    = 7;
  localparam int unsigned RS1_LSB   = 15;
  localparam int unsigned RS2_LSB   = 20;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Index is valid for a register file of reg_num entries.
  function automatic logic idx_in_range(input logic [REG_IDX_W-1:0] idx,
                                        input int unsigned          reg_num);
    return (32'(idx) < reg_num);
  endfunction

endpackage : de_pkg

// File: rtl/de_regfile.sv
// -----------------------------------------------------------------------------
// de_regfile -- architectural register file for the decode stage.
//   Two asynchronous read ports, one synchronous write port, x0 hard-wired to
//   zero, optional write-to-read forwarding.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (clears all entries)
//   ra1/ra2       : read indices; 0 or out-of-range indices read as 0
//   rd1/rd2       : read data (combinational)
//   we/wa/wd      : write enable, index, data; x0 and out-of-range are ignored
// -----------------------------------------------------------------------------
module de_regfile
  import de_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_NUM    = 32,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_IDX_W-1:0]  ra1,
  input  logic [REG_IDX_W-1:0]  ra2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
  input  logic                  we,
  input  logic [REG_IDX_W-1:0]  wa,
  input  logic [DATA_WIDTH-1:0] wd
);

  // Storage is sized to REG_NUM, so indices are trimmed to the array's width
  // only after the range check has filtered them.
  localparam int unsigned IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  logic [DATA_WIDTH-1:0] regs [REG_NUM];
  logic                  wr_en;

  assign wr_en = we && (wa != '0) && idx_in_range(wa, REG_NUM);

  // Write port; reset clears every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(REG_NUM); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wa[IDX_W-1:0]] <= wd;
    end
  end

  // Read port 1: forward the in-flight write when enabled.
  always_comb begin
    rd1 = '0;
    if ((ra1 != '0) && idx_in_range(ra1, REG_NUM)) begin
      if (BYPASS && wr_en && (wa == ra1)) begin
        rd1 = wd;
      end else begin
        rd1 = regs[ra1[IDX_W-1:0]];
      end
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    rd2 = '0;
    if ((ra2 != '0) && idx_in_range(ra2, REG_NUM)) begin
      if (BYPASS && wr_en && (wa == ra2)) begin
        rd2 = wd;
      end else begin
        rd2 = regs[ra2[IDX_W-1:0]];
      end
    end
  end

endmodule : de_regfile

// File: rtl/de_pipe.sv
// -----------------------------------------------------------------------------
// de_pipe -- single-entry decode pipeline stage with register-file read.
//   Holds one fetched instruction behind a valid/ready handshake, exposes its
//   source register indices and operand values, flags register indices beyond
//   the configured register count, and counts back-pressure cycles.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   in_valid/in_ready           : fetch-side handshake (in_ready combinational)
//   in_instr/in_pc/in_pcn       : fetched word, its pc, pc+4
//   flush                       : kill the held instruction (redirect)
//   out_valid/out_ready         : execute-side handshake
//   out_instr/out_pc/out_pcn    : held instruction and pcs
//   out_rs1/out_rs2             : source register fields of the held word
//   out_rd1/out_rd2             : operand values read for rs1/rs2
//   out_bad_reg                 : held word names a register >= REG_NUM
//   wb_rd/wb_we/wb_wd           : register write-back port
//   stall_cnt                   : saturating count of back-pressure cycles
// -----------------------------------------------------------------------------
module de_pipe
  import de_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned REG_NUM    = 32,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_instr,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  input  logic [ADDR_WIDTH-1:0] in_pcn,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [ADDR_WIDTH-1:0] out_pcn,
  output logic [REG_IDX_W-1:0]  out_rs1,
  output logic [REG_IDX_W-1:0]  out_rs2,
  output logic [DATA_WIDTH-1:0] out_rd1,
  output logic [DATA_WIDTH-1:0] out_rd2,
  output logic                  out_bad_reg,
  input  logic [REG_IDX_W-1:0]  wb_rd,
  input  logic                  wb_we,
  input  logic [DATA_WIDTH-1:0] wb_wd,
  output logic [31:0]           stall_cnt
);

  localparam logic [ADDR_WIDTH-1:0] NOP_W = ADDR_WIDTH'(NOP_INSTR);

  logic                 take;
  logic [REG_IDX_W-1:0] rd_field;

  // Stage accepts whenever it is empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign take     = in_valid && in_ready;

  // Stage register: flush beats load, load beats drain, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= NOP_W;
      out_pc    <= '0;
      out_pcn   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_instr <= NOP_W;
    end else if (take) begin
      out_valid <= 1'b1;
      out_instr <= in_instr;
      out_pc    <= in_pc;
      out_pcn   <= in_pcn;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Back-pressure counter; saturates and survives flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  // Register fields decoded straight from the held word.
  assign out_rs1  = out_instr[RS1_LSB +: REG_IDX_W];
  assign out_rs2  = out_instr[RS2_LSB +: REG_IDX_W];
  assign rd_field = out_instr[RD_LSB  +: REG_IDX_W];

  // Only meaningful for reduced register files (e.g. RV32E).
  assign out_bad_reg = out_valid && (!idx_in_range(out_rs1, REG_NUM) ||
                                     !idx_in_range(out_rs2, REG_NUM) ||
                                     !idx_in_range(rd_field, REG_NUM));

  de_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_NUM    (REG_NUM),
    .BYPASS     (BYPASS)
  ) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (out_rs1),
    .ra2 (out_rs2),
    .rd1 (out_rd1),
    .rd2 (out_rd2),
    .we  (wb_we),
    .wa  (wb_rd),
    .wd  (wb_wd)
  );

endmodule : de_pipe

// File: tb/tb_de_pipe.sv
// -----------------------------------------------------------------------------
// tb_de_pipe -- directed self-checking bench for de_pipe. Three instances share
// every input: default (BYPASS=1, REG_NUM=32), no-bypass (BYPASS=0) and a
// reduced register file (REG_NUM=16).
// -----------------------------------------------------------------------------
module tb_de_pipe;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_pcn;
  logic        flush;
  logic        out_ready;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [31:0] wb_wd;

  logic        in_ready_d, out_valid_d, out_bad_reg_d;
  logic [31:0] out_instr_d, out_pc_d, out_pcn_d, out_rd1_d, out_rd2_d, stall_cnt_d;
  logic [4:0]  out_rs1_d, out_rs2_d;

  logic        in_ready_n, out_valid_n, out_bad_reg_n;
  logic [31:0] out_instr_n, out_pc_n, out_pcn_n, out_rd1_n, out_rd2_n, stall_cnt_n;
  logic [4:0]  out_rs1_n, out_rs2_n;

  logic        in_ready_s, out_valid_s, out_bad_reg_s;
  logic [31:0] out_instr_s, out_pc_s, out_pcn_s, out_rd1_s, out_rd2_s, stall_cnt_s;
  logic [4:0]  out_rs1_s, out_rs2_s;

  int n_vec;
  int n_err;

  logic [31:0] b2b_instr [3];

  de_pipe dut_d (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d),
    .in_instr(in_instr), .in_pc(in_pc), .in_pcn(in_pcn), .flush(flush),
    .out_valid(out_valid_d), .out_ready(out_ready), .out_instr(out_instr_d),
    .out_pc(out_pc_d), .out_pcn(out_pcn_d), .out_rs1(out_rs1_d), .out_rs2(out_rs2_d),
    .out_rd1(out_rd1_d), .out_rd2(out_rd2_d), .out_bad_reg(out_bad_reg_d),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_wd(wb_wd), .stall_cnt(stall_cnt_d)
  );

  de_pipe #(.BYPASS(1'b0)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_instr(in_instr), .in_pc(in_pc), .in_pcn(in_pcn), .flush(flush),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_instr(out_instr_n),
    .out_pc(out_pc_n), .out_pcn(out_pcn_n), .out_rs1(out_rs1_n), .out_rs2(out_rs2_n),
    .out_rd1(out_rd1_n), .out_rd2(out_rd2_n), .out_bad_reg(out_bad_reg_n),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_wd(wb_wd), .stall_cnt(stall_cnt_n)
  );

  de_pipe #(.REG_NUM(16)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_instr(in_instr), .in_pc(in_pc), .in_pcn(in_pcn), .flush(flush),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_instr(out_instr_s),
    .out_pc(out_pc_s), .out_pcn(out_pcn_s), .out_rs1(out_rs1_s), .out_rs2(out_rs2_s),
    .out_rd1(out_rd1_s), .out_rd2(out_rd2_s), .out_bad_reg(out_bad_reg_s),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_wd(wb_wd), .stall_cnt(stall_cnt_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle just past it.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] instr, input logic [31:0] pc);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_pc     = pc;
    in_pcn    = pc + 32'd4;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; in_pcn = '0;
    flush = 1'b0; out_ready = 1'b0; wb_rd = '0; wb_we = 1'b0; wb_wd = '0;
    #2;
    n_vec++; if (out_valid_d !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0h want 0", out_valid_d); end
    n_vec++; if (out_instr_d !== NOP) begin n_err++; $display("FAIL rst_instr got %08h want %08h", out_instr_d, NOP); end
    n_vec++; if (out_pc_d !== 32'h0 || out_pcn_d !== 32'h0) begin n_err++; $display("FAIL rst_pc got %08h/%08h want 0/0", out_pc_d, out_pcn_d); end
    n_vec++; if (stall_cnt_d !== 32'h0) begin n_err++; $display("FAIL rst_stall got %0d want 0", stall_cnt_d); end
    n_vec++; if (in_ready_d !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %0h want 1", in_ready_d); end
    step(); step();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (in_ready_d !== 1'b1) begin n_err++; $display("FAIL rst_after_ready got %0h want 1", in_ready_d); end
  endtask

  task automatic test_basic;
    load(32'h0020_81B3, 32'h0000_0100);
    n_vec++; if (out_valid_d !== 1'b1) begin n_err++; $display("FAIL basic_valid got %0h want 1", out_valid_d); end
    n_vec++; if (out_rs1_d !== 5'd1) begin n_err++; $display("FAIL basic_rs1 got %0d want 1", out_rs1_d); end
    n_vec++; if (out_rs2_d !== 5'd2) begin n_err++; $display("FAIL basic_rs2 got %0d want 2", out_rs2_d); end
    n_vec++; if (out_pcn_d !== 32'h104) begin n_err++; $display("FAIL basic_pcn got %08h want 00000104", out_pcn_d); end
    n_vec++; if (out_pc_d !== 32'h100) begin n_err++; $display("FAIL basic_pc got %08h want 00000100", out_pc_d); end
    n_vec++; if (out_instr_d !== 32'h0020_81B3) begin n_err++; $display("FAIL basic_instr got %08h want 002081b3", out_instr_d); end
    n_vec++; if (out_rd1_d !== 32'h0 || out_rd2_d !== 32'h0) begin n_err++; $display("FAIL basic_rd got %08h/%08h want 0/0", out_rd1_d, out_rd2_d); end
    n_vec++; if (out_bad_reg_d !== 1'b0) begin n_err++; $display("FAIL basic_bad got %0h want 0", out_bad_reg_d); end
    step();
    n_vec++; if (out_valid_d !== 1'b0) begin n_err++; $display("FAIL basic_drain got %0h want 0", out_valid_d); end
  endtask

  task automatic test_back_to_back;
    b2b_instr[0] = 32'h0010_0093;
    b2b_instr[1] = 32'h0020_0113;
    b2b_instr[2] = 32'h0031_0193;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_instr = b2b_instr[i];
      in_pc    = 32'h200 + 32'(i * 4);
      in_pcn   = 32'h204 + 32'(i * 4);
      step();
      n_vec++; if (out_instr_d !== b2b_instr[i]) begin n_err++; $display("FAIL b2b_instr%0d got %08h want %08h", i, out_instr_d, b2b_instr[i]); end
      n_vec++; if (out_valid_d !== 1'b1 || in_ready_d !== 1'b1) begin n_err++; $display("FAIL b2b_hs%0d got v=%0h r=%0h want 1/1", i, out_valid_d, in_ready_d); end
      n_vec++; if (out_pc_d !== 32'h200 + 32'(i * 4)) begin n_err++; $display("FAIL b2b_pc%0d got %08h want %08h", i, out_pc_d, 32'h200 + 32'(i * 4)); end
    end
    in_valid = 1'b0;
    step();
    n_vec++; if (out_valid_d !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %0h want 0", out_valid_d); end
  endtask

  task automatic test_stall;
    load(32'h0040_0213, 32'h300);
    in_valid  = 1'b1;
    in_instr  = 32'h0050_0293;
    in_pc     = 32'h304;
    in_pcn    = 32'h308;
    out_ready = 1'b0;
    #1;
    n_vec++; if (in_ready_d !== 1'b0) begin n_err++; $display("FAIL stall_ready got %0h want 0", in_ready_d); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (out_instr_d !== 32'h0040_0213 || out_pc_d !== 32'h300 || out_pcn_d !== 32'h304 || out_valid_d !== 1'b1) begin
        n_err++; $display("FAIL stall_hold%0d got %08h/%08h/%08h v=%0h want 00400213/00000300/00000304 v=1", i, out_instr_d, out_pc_d, out_pcn_d, out_valid_d);
      end
    end
    n_vec++; if (stall_cnt_d !== 32'd3) begin n_err++; $display("FAIL stall_cnt got %0d want 3", stall_cnt_d); end
    out_ready = 1'b1;
    step();
    n_vec++; if (out_instr_d !== 32'h0050_0293) begin n_err++; $display("FAIL stall_release got %08h want 00500293", out_instr_d); end
  endtask

  task automatic test_flush;
    in_valid  = 1'b1;
    in_instr  = 32'h0060_0313;
    out_ready = 1'b0;
    flush     = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_vec++; if (out_valid_d !== 1'b0) begin n_err++; $display("FAIL flush_valid got %0h want 0", out_valid_d); end
    n_vec++; if (out_instr_d !== NOP) begin n_err++; $display("FAIL flush_instr got %08h want %08h", out_instr_d, NOP); end
    n_vec++; if (stall_cnt_d !== 32'd4) begin n_err++; $display("FAIL flush_stall got %0d want 4", stall_cnt_d); end
    n_vec++; if (in_ready_d !== 1'b1) begin n_err++; $display("FAIL flush_ready got %0h want 1", in_ready_d); end
  endtask

  task automatic test_bypass;
    load(32'h0002_8033, 32'h400);
    out_ready = 1'b0;
    wb_we = 1'b1; wb_rd = 5'd5; wb_wd = 32'hDEAD_BEEF;
    #1;
    n_vec++; if (out_rd1_d !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL byp_same got %08h want deadbeef", out_rd1_d); end
    n_vec++; if (out_rd1_n !== 32'h0) begin n_err++; $display("FAIL nobyp_same got %08h want 0", out_rd1_n); end
    n_vec++; if (out_rd1_s !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL byp16_same got %08h want deadbeef", out_rd1_s); end
    step();
    wb_we = 1'b0;
    #1;
    n_vec++; if (out_rd1_n !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL nobyp_next got %08h want deadbeef", out_rd1_n); end
    n_vec++; if (out_rd1_d !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL byp_next got %08h want deadbeef", out_rd1_d); end
  endtask

  task automatic test_bad_reg;
    load(32'h0110_8033, 32'h500);
    out_ready = 1'b0;
    n_vec++; if (out_rs1_s !== 5'd1 || out_rs2_s !== 5'd17) begin n_err++; $display("FAIL bad_fields got %0d/%0d want 1/17", out_rs1_s, out_rs2_s); end
    wb_we = 1'b1; wb_rd = 5'd17; wb_wd = 32'hCAFE_F00D;
    #1;
    n_vec++; if (out_rd2_s !== 32'h0) begin n_err++; $display("FAIL bad_nobyp got %08h want 0", out_rd2_s); end
    n_vec++; if (out_rd2_d !== 32'hCAFE_F00D) begin n_err++; $display("FAIL full_byp17 got %08h want cafef00d", out_rd2_d); end
    step();
    wb_we = 1'b0;
    #1;
    n_vec++; if (out_bad_reg_s !== 1'b1) begin n_err++; $display("FAIL bad_flag got %0h want 1", out_bad_reg_s); end
    n_vec++; if (out_bad_reg_d !== 1'b0) begin n_err++; $display("FAIL bad_flag32 got %0h want 0", out_bad_reg_d); end
    n_vec++; if (out_rd2_s !== 32'h0) begin n_err++; $display("FAIL bad_rd2 got %08h want 0", out_rd2_s); end
    n_vec++; if (out_rd1_s !== 32'h0) begin n_err++; $display("FAIL bad_alias_x1 got %08h want 0", out_rd1_s); end
    n_vec++; if (out_rd2_d !== 32'hCAFE_F00D) begin n_err++; $display("FAIL full_x17 got %08h want cafef00d", out_rd2_d); end
    // rd field out of range (rd = 20), sources in range.
    load(32'h0000_0A33, 32'h504);
    n_vec++; if (out_bad_reg_s !== 1'b1) begin n_err++; $display("FAIL bad_rd_field got %0h want 1", out_bad_reg_s); end
    step();
    n_vec++; if (out_bad_reg_s !== 1'b0) begin n_err++; $display("FAIL bad_invalid got %0h want 0", out_bad_reg_s); end
  endtask

  task automatic test_x0;
    load(32'h0000_0033, 32'h600);
    out_ready = 1'b0;
    wb_we = 1'b1; wb_rd = 5'd0; wb_wd = 32'h0000_1234;
    #1;
    n_vec++; if (out_rd1_d !== 32'h0) begin n_err++; $display("FAIL x0_same got %08h want 0", out_rd1_d); end
    step();
    wb_we = 1'b0;
    #1;
    n_vec++; if (out_rd1_d !== 32'h0 || out_rd1_n !== 32'h0) begin n_err++; $display("FAIL x0_next got %08h/%08h want 0/0", out_rd1_d, out_rd1_n); end
  endtask

  task automatic test_async_reset;
    load(32'h0002_8033, 32'h700);
    out_ready = 1'b0;
    step();
    n_vec++; if (out_valid_d !== 1'b1 || stall_cnt_d === 32'h0) begin n_err++; $display("FAIL ar_pre got v=%0h cnt=%0d want v=1 cnt>0", out_valid_d, stall_cnt_d); end
    rst = 1'b1;
    #1;
    n_vec++; if (out_valid_d !== 1'b0) begin n_err++; $display("FAIL ar_valid got %0h want 0", out_valid_d); end
    n_vec++; if (out_instr_d !== NOP || out_pc_d !== 32'h0) begin n_err++; $display("FAIL ar_instr got %08h/%08h want %08h/0", out_instr_d, out_pc_d, NOP); end
    n_vec++; if (stall_cnt_d !== 32'h0) begin n_err++; $display("FAIL ar_stall got %0d want 0", stall_cnt_d); end
    n_vec++; if (in_ready_d !== 1'b1) begin n_err++; $display("FAIL ar_ready got %0h want 1", in_ready_d); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (in_ready_d !== 1'b1) begin n_err++; $display("FAIL ar_after_ready got %0h want 1", in_ready_d); end
    load(32'h0002_8033, 32'h800);
    n_vec++; if (out_rd1_d !== 32'h0) begin n_err++; $display("FAIL ar_regs got %08h want 0", out_rd1_d); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_flush();
    test_bypass();
    test_bad_reg();
    test_x0();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_de_pipe
